core_sequencer: RTL

- Parametrised, stateful successor to the single-cycle core decoder.
- Owns the core state register, the memory-read stall counter, the forward bracket-scan nesting counter and the loop-cache occupancy counter.
- Emits per-cycle write enables and mux selects for the accumulator, stack pointer, head, loop cache, memory and PC.
- Sits between the instruction fetch and the core datapath.
- Detects loop overflow, scan overflow and unmatched CBB, then halts.

---
 rtl/core_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: stateful core control with memory stall, forward bracket scan and loop-cache tracking
module core_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int DEPTH_W     = 8,
  parameter int LOOP_DEPTH  = 16,
  parameter int LOOP_W      = $clog2(LOOP_DEPTH+1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [3:0]         instruction,
  input  logic               acc_zero,
  output logic               acc_write,
  output logic               acc_from_mem,
  output logic               stack_write,
  output logic               head_write,
  output logic               cache_write,
  output logic               cache_pop,
  output logic               mem_write,
  output logic               alu_dec,
  output logic               pc_write,
  output logic               pc_from_cache,
  output logic [1:0]         state,
  output logic [DEPTH_W-1:0] scan_depth,
  output logic [LOOP_W-1:0]  loop_level,
  output logic               error
);
  typedef enum logic [1:0] {CORE = 2'd0, STALL = 2'd1, SCAN = 2'd2, HALT = 2'd3} state_e;
  localparam logic [3:0] OP_INC = 4'd0;
  localparam logic [3:0] OP_DEC = 4'd1;
  localparam logic [3:0] OP_PSH = 4'd2;
  localparam logic [3:0] OP_POP = 4'd3;
  localparam logic [3:0] OP_MVR = 4'd4;
  localparam logic [3:0] OP_MVL = 4'd5;
  localparam logic [3:0] OP_CBF = 4'd6;
  localparam logic [3:0] OP_CBB = 4'd7;
  localparam logic [3:0]         LAT       = 4'(MEM_LATENCY);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [LOOP_W-1:0]  LOOP_MAX  = LOOP_W'(LOOP_DEPTH);
  state_e               state_q, state_d;
  logic [3:0]           stall_q, stall_d;
  logic                 bubble_q, bubble_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [LOOP_W-1:0]    loop_q, loop_d;
  logic                 err_q, err_d;
  logic                 live_q;
  logic                 v;
  // live_q masks the first cycle after reset release so no instruction is acted on then
  assign v          = instr_valid & live_q;
  assign state      = state_q;
  assign scan_depth = depth_q;
  assign loop_level = loop_q;
  assign error      = err_q;
  // state and counter registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= CORE;
      stall_q  <= '0;
      bubble_q <= 1'b0;
      depth_q  <= '0;
      loop_q   <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      depth_q  <= depth_d;
      loop_q   <= loop_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end
  // next-state and per-cycle control decode
  always_comb begin
    state_d       = state_q;
    stall_d       = stall_q;
    bubble_d      = bubble_q;
    depth_d       = depth_q;
    loop_d        = loop_q;
    err_d         = err_q;
    acc_write     = 1'b0;
    acc_from_mem  = 1'b0;
    stack_write   = 1'b0;
    head_write    = 1'b0;
    cache_write   = 1'b0;
    cache_pop     = 1'b0;
    mem_write     = 1'b0;
    alu_dec       = 1'b0;
    pc_write      = 1'b0;
    pc_from_cache = 1'b0;
    case (state_q)
      CORE: if (v) begin
        case (instruction)
          OP_INC, OP_DEC: begin
            acc_write = 1'b1;
            mem_write = 1'b1;
            pc_write  = 1'b1;
            alu_dec   = instruction == OP_DEC;
          end
          OP_PSH: begin
            stack_write = 1'b1;
            mem_write   = 1'b1;
            pc_write    = 1'b1;
          end
          OP_POP, OP_MVR, OP_MVL: begin
            stack_write = instruction == OP_POP;
            head_write  = instruction != OP_POP;
            alu_dec     = instruction != OP_MVR;
            state_d     = STALL;
            stall_d     = LAT;
            bubble_d    = 1'b0;
          end
          OP_CBF: begin
            if (acc_zero) begin
              pc_write = 1'b1;
              depth_d  = '0;
              state_d  = SCAN;
            end else if (loop_q == LOOP_MAX) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              cache_write = 1'b1;
              pc_write    = 1'b1;
              loop_d      = loop_q + LOOP_W'(1);
            end
          end
          OP_CBB: begin
            if (loop_q == '0) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else if (!acc_zero) begin
              pc_write      = 1'b1;
              pc_from_cache = 1'b1;
              state_d       = STALL;
              stall_d       = 4'd1;
              bubble_d      = 1'b1;
            end else begin
              cache_pop = 1'b1;
              pc_write  = 1'b1;
              loop_d    = loop_q - LOOP_W'(1);
            end
          end
          default: pc_write = 1'b1;
        endcase
      end
      STALL: begin
        if (stall_q > 4'd1) begin
          stall_d = stall_q - 4'd1;
        end else if (bubble_q) begin
          state_d  = CORE;
          stall_d  = '0;
          bubble_d = 1'b0;
        end else if (v) begin
          acc_write    = 1'b1;
          acc_from_mem = 1'b1;
          pc_write     = 1'b1;
          state_d      = CORE;
          stall_d      = '0;
        end
      end
      SCAN: if (v) begin
        pc_write = 1'b1;
        if (instruction == OP_CBF) begin
          if (depth_q == DEPTH_MAX) begin
            pc_write = 1'b0;
            err_d    = 1'b1;
            state_d  = HALT;
          end else begin
            depth_d = depth_q + DEPTH_W'(1);
          end
        end else if (instruction == OP_CBB) begin
          state_d = depth_q == '0 ? CORE : SCAN;
          depth_d = depth_q == '0 ? depth_q : depth_q - DEPTH_W'(1);
        end
      end
      default: ;
    endcase
  end
endmodule
